// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the control FSM and the sequential
// multiply/divide unit that owns HI/LO.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, abort, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, abort, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Radix-2 sequential MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
// Optional MULDIV_EARLY_OUT_EN: multiplies stop once remaining multiplier bits are zero.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic               is_div_q, neg_q, neg_r, dbz_q;
    logic [WIDTH-1:0]   mb_q;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dbz_out;

    logic               sa, sb, div_zero_req, last_iter;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     rem_sh, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

    // Signed ops run on magnitudes; signs are re-applied in FIX
    assign sa           = ~bus.op[0] & bus.a[WIDTH-1];
    assign sb           = ~bus.op[0] & bus.b[WIDTH-1];
    assign mag_a        = sa ? -bus.a : bus.a;
    assign mag_b        = sb ? -bus.b : bus.b;
    assign div_zero_req = bus.op[1] & (bus.b == '0);

    // Restoring divide: acc = {remainder, dividend/quotient}
    assign rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, mb_q};

    always_comb begin
        last_iter = (cnt == CW'(1));
`ifdef MULDIV_EARLY_OUT_EN
        if (!is_div_q && mb_q[WIDTH-1:1] == '0)
            last_iter = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start && !bus.abort) state_d = div_zero_req ? FIX : CALC;
            CALC: begin
                if (bus.abort)      state_d = IDLE;
                else if (last_iter) state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (dbz_q)         {res_hi, res_lo} = acc;
        else if (is_div_q) {res_hi, res_lo} = {rem, quo};
        else               {res_hi, res_lo} = prod;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dbz_q    <= 1'b0;
            mb_q     <= '0;
            acc      <= '0;
            mcand    <= '0;
            cnt      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_out  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            dbz_out <= 1'b0;
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
            case (state_q)
                IDLE: if (bus.start && !bus.abort) begin
                    is_div_q <= bus.op[1];
                    neg_q    <= sa ^ sb;
                    neg_r    <= bus.op[1] & sa;
                    dbz_q    <= div_zero_req;
                    mb_q     <= mag_b;
                    mcand    <= {{WIDTH{1'b0}}, mag_a};
                    cnt      <= CW'(WIDTH);
                    if (div_zero_req)   acc <= {bus.a, {WIDTH{1'b1}}};
                    else if (bus.op[1]) acc <= {{WIDTH{1'b0}}, mag_a};
                    else                acc <= '0;
                end
                CALC: if (!bus.abort) begin
                    cnt <= cnt - CW'(1);
                    if (is_div_q) begin
                        if (!diff[WIDTH]) acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else              acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    end else begin
                        if (mb_q[0]) acc <= acc + mcand;
                        mcand <= mcand << 1;
                        mb_q  <= mb_q >> 1;
                    end
                end
                // Result write is last so it overrides a same-edge MTHI/MTLO
                FIX: if (!bus.abort) begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    done_q  <= 1'b1;
                    dbz_out <= dbz_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_out;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, hand sequences, random vs model.
module tb_muldiv_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(W)) bus();
    muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
        logic         dbz;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected result from plain integer arithmetic on the architectural values
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
        longint x, y, p, q, r;
        x = op[0] ? longint'({32'h0, a}) : longint'($signed(a));
        y = op[0] ? longint'({32'h0, b}) : longint'($signed(b));
        ed = 1'b0;
        if (!op[1]) begin
            p  = x * y;
            eh = p[63:32];
            el = p[31:0];
        end else if (b == '0) begin
            ed = 1'b1;
            eh = a;
            el = '1;
        end else begin
            q  = x / y;
            r  = x % y;
            eh = r[31:0];
            el = q[31:0];
        end
    endfunction

    function automatic int lat_model(input logic [1:0] op, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        longint m;
        int n;
`endif
        if (op[1]) return (b == '0) ? 2 : W + 2;
`ifdef MULDIV_EARLY_OUT_EN
        m = (op == 2'b00) ? longint'($signed(b)) : longint'({32'h0, b});
        if (m < 0) m = -m;
        n = 0;
        for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
        return 2 + ((n < 1) ? 1 : n);
`else
        return W + 2;
`endif
    endfunction

    // Issues one op; lat = edge number (start edge = 1) where done was seen
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int pulse_at, output int lat);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        check("busy_after_start", bus.busy, 1);
        while (!bus.done && lat < 200) begin
            if (lat == pulse_at - 1) begin
                bus.start = 1'b1; bus.op = ~op; bus.a = ~a; bus.b = ~b;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            lat++;
        end
    endtask

    task automatic check_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                            input logic ed, input int pulse_at);
        int lat;
        run_op(op, a, b, pulse_at, lat);
        check({name, "_latency"}, lat, lat_model(op, b));
        check({name, "_hi"}, bus.hi, eh);
        check({name, "_lo"}, bus.lo, el);
        check({name, "_dbz"}, bus.div_by_zero, ed);
        @(posedge clk); #1;
        check({name, "_done_pulse_ends"}, {bus.done, bus.div_by_zero, bus.busy}, 0);
    endtask

    initial begin
        logic [W-1:0] eh, el;
        logic         ed;
        logic         seen;
        int           lat;

        tbl[0] = '{2'b00, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[2] = '{2'b10, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3] = '{2'b11, 32'h7,        32'h2,        32'h1,        32'h3,        1'b0};
        tbl[4] = '{2'b10, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 1'b1};
        tbl[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
        tbl[6] = '{2'b01, 32'h9,        32'h3,        32'h0,        32'd27,       1'b0};
        tbl[7] = '{2'b11, 32'h5,        32'h0,        32'h5,        32'hFFFFFFFF, 1'b1};
        tbl[8] = '{2'b10, 32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 1'b0};
        tbl[9] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0};

        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.abort = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {bus.hi, bus.lo, bus.busy, bus.done, bus.div_by_zero}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", {bus.busy, bus.done}, 0);

        foreach (tbl[i])
            check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                     tbl[i].hi, tbl[i].lo, tbl[i].dbz, 0);

        // Direct writes in IDLE
        @(negedge clk);
        bus.hi_we = 1; bus.wdata = 32'h00001111;
        @(negedge clk);
        bus.hi_we = 0; bus.lo_we = 1; bus.wdata = 32'h00002222;
        @(negedge clk);
        bus.lo_we = 0;
        check("mthi_mtlo", {bus.hi, bus.lo}, {32'h00001111, 32'h00002222});

        // MULT 5*6, ignored start at edge 10, abort at edge 20
        @(negedge clk);
        bus.start = 1; bus.op = 2'b00; bus.a = 5; bus.b = 6;
        @(posedge clk); #1;
        bus.start = 0;
        seen = 1'b0;
        for (int e = 2; e <= 30; e++) begin
            if (e == 10) begin bus.start = 1; bus.a = 32'h77; bus.b = 32'h99; end
            if (e == 20) bus.abort = 1;
            @(posedge clk); #1;
            bus.start = 0;
            bus.abort = 0;
            if (bus.done) seen = 1'b1;
            if (e == 20) check("abort_clears_busy", bus.busy, 0);
        end
        check("abort_no_done", seen, 0);
        check("abort_keeps_hilo", {bus.hi, bus.lo}, {32'h00001111, 32'h00002222});

        // Restart with a second start pulse mid-flight: operands must not be resampled
        check_op("start_ignored_busy", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 10);

        // MTHI/MTLO held across the completion edge: the result wins
        @(negedge clk);
        bus.hi_we = 1; bus.lo_we = 1; bus.wdata = 32'hDEADBEEF;
        run_op(2'b11, 32'd100, 32'd7, 0, lat);
        bus.hi_we = 0; bus.lo_we = 0;
        check("result_beats_we", {bus.hi, bus.lo}, {32'd2, 32'd14});

        // Asynchronous reset mid-operation
        @(negedge clk);
        bus.start = 1; bus.op = 2'b00; bus.a = 5; bus.b = 6;
        @(posedge clk); #1;
        bus.start = 0;
        for (int e = 2; e <= 15; e++) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        check("async_reset_mid_op", {bus.hi, bus.lo, bus.busy, bus.done, bus.div_by_zero}, 0);
        @(negedge clk);
        reset = 1'b1;

        @(negedge clk);
        bus.lo_we = 1; bus.wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        bus.lo_we = 0;
        check("mtlo_idle", bus.lo, 32'hA5A5A5A5);

        // Abort while in FIX (edge 2 of a divide-by-zero): no done, hi/lo unchanged
        @(negedge clk);
        bus.start = 1; bus.op = 2'b11; bus.a = 32'h1234; bus.b = 0;
        @(posedge clk); #1;
        bus.start = 0; bus.abort = 1;
        @(posedge clk); #1;
        bus.abort = 0;
        check("abort_in_fix", {bus.done, bus.busy, bus.lo}, {2'b00, 32'hA5A5A5A5});

        for (int i = 0; i < 40; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                3:       b = 32'h80000000;
                default: b = $urandom;
            endcase
            model(op, a, b, eh, el, ed);
            check_op($sformatf("rand%0d", i), op, a, b, eh, el, ed, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
